interface_i_rd: RTL and testbench
=================================

Name: interface_i_rd

Overview:
- Read-side counterpart of the memory-mapped write-enable decoder.
- Accepts CPU load requests (ADDR, RE) and returns RDATA from one of two sources:
  - DMEM, when ADDR[11]=0;
  - a peripheral read register, when ADDR[11]=1.
- Fast sources return registered data. The SD buffer is slow and uses a req/ack handshake with a timeout.
- Holds the CPU with STALL until RDATA is valid. Also contains sticky button-event latches that clear on read.

Parameters:
- TIMEOUT, default 255: max cycles to wait for SD_BUF_ACK before aborting.
- ERR_WORD, default 32'hDEAD_BEEF: RDATA value returned on timeout or unmapped peripheral address.
- BTN_W, default 5: number of button inputs.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ADDR  in  32  CPU byte address; only ADDR[11:0] decoded.
- RE  in  1  CPU read request, held until STALL=0.
- DMEM_RDATA  in  32  DMEM read data, valid 1 cycle after DMEM_RE.
- DMEM_RE  out  1  DMEM read strobe.
- MP3_VOL_Q  in  32  MP3 volume register readback.
- MP3_SW_Q  in  32  MP3 switch register readback.
- SWITCH  in  16  board switches, zero-extended.
- BTN  in  BTN_W  raw synchronized buttons.
- LED_Q  in  32  LED register readback.
- VOL_Q  in  32  volume ADC value.
- SD_STATUS  in  32  SD controller status.
- SD_BUF_REQ  out  1  single-cycle request to SD buffer.
- SD_BUF_ACK  in  1  SD buffer data-valid pulse.
- SD_BUF_DATA  in  32  SD buffer data, valid with ACK.
- RDATA  out  32  registered read data.
- STALL  out  1  CPU hold.
- RD_ERR  out  1  sticky; set on timeout or unmapped read, cleared by reset only.

Behaviour:
- Reset values: RDATA=0, STALL=0, DMEM_RE=0, SD_BUF_REQ=0, RD_ERR=0, button latches=0, state=IDLE, timeout counter=0.
- Address map, read side, when ADDR[11]=1:

  | Address | Source | Type |
  |---|---|---|
  | 804 | MP3_VOL_Q | fast |
  | 80C | MP3_SW_Q | fast |
  | 810 | {16'b0,SWITCH} | fast |
  | 814 | {zeros, BTN latches} | fast, clear-on-read |
  | 818 | LED_Q | fast |
  | 840 | VOL_Q | fast |
  | 844 | SD_BUF_DATA | slow |
  | 848 | SD_STATUS | fast |
  | any other with ADDR[11]=1 | ERR_WORD, set RD_ERR | — |

- FSM states: IDLE, DMEM_WAIT, SD_REQ, SD_WAIT, DONE.
- IDLE, RE=0: STALL=0; nothing else happens.
- IDLE, RE=1:
  - STALL goes 1 combinationally in the same cycle.
  - DMEM address: assert DMEM_RE → DMEM_WAIT.
  - Fast peripheral: register the selected value into RDATA → DONE.
  - 844: go to SD_REQ.
- DMEM_WAIT: RDATA<=DMEM_RDATA → DONE.
- SD_REQ: SD_BUF_REQ=1 for exactly one cycle; clear counter → SD_WAIT.
- SD_WAIT:
  - ACK=1: RDATA<=SD_BUF_DATA → DONE.
  - Else counter++.
  - Counter==TIMEOUT: RDATA<=ERR_WORD, RD_ERR<=1 → DONE.
- DONE: STALL=0 for one cycle (CPU samples RDATA) → IDLE.
  - RE still high in IDLE next cycle is a new request. The CPU drops or changes RE/ADDR after sampling.
- Latency:
  - Fast: 1 stall cycle; RDATA valid in DONE.
  - DMEM: 2 stall cycles.
  - SD: 2 + ACK delay, or 2 + TIMEOUT stall cycles.
- ACK during SD_REQ (same cycle as REQ) is accepted; go to DONE with that data.
- Stray ACK in any other state is ignored.
- Button latches:
  - Per-bit rising edge of BTN sets latch; the previous-BTN register resets to 0.
  - A read of 814 returns the latch value and clears it at IDLE→DONE.
  - A rising edge on the same cycle as the clear: set wins, so the bit stays 1.
- Reset mid-SD_WAIT: return to IDLE immediately. An ACK arriving later is ignored.
- RE deasserted mid-transaction (protocol violation): the transaction still completes. DONE is entered normally.

Decomposition:
- Package interface_io_pkg:
  - Address localparams (ADDR_MP3_VOL=12'h804 … ADDR_SD=12'h848, ADDR_SWITCH=12'h810, ADDR_BTN=12'h814), shared with the write decoder.
  - FSM state encoding.
- One sub-module, btn_event_latch: edge detect plus sticky set/clear for BTN_W bits.

Test Plan:
- Read DMEM at 0x100 with DMEM_RDATA=32'h1234_5678 → DMEM_RE pulses 1 cycle; STALL high 2 cycles; RDATA=32'h1234_5678 in DONE.
- Read 0x810 with SWITCH=16'hA5C3 → 1 stall cycle; RDATA=32'h0000_A5C3; RD_ERR=0.
- Read 0x844, ACK 3 cycles after REQ, SD_BUF_DATA=32'hCAFE_0001 → one REQ pulse; STALL 5 cycles; RDATA=32'hCAFE_0001.
- Read 0x844 with no ACK and TIMEOUT=4 → RDATA=32'hDEAD_BEEF, RD_ERR=1 after 6 stall cycles; later ACK ignored.
- BTN[2] rising, then read 0x814 → RDATA=32'h4; immediate second read → 0. Second case: a BTN[0] edge on the clear cycle of a read → next read returns 32'h1.
- Read unmapped 0x8F0 → RDATA=ERR_WORD, RD_ERR=1. Assert RST during SD_WAIT → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/interface_io_pkg.sv
// Shared definitions for the memory-mapped I/O decoders: peripheral
// address map (low 12 bits) and the read-side FSM / source encodings.
package interface_io_pkg;

  localparam logic [11:0] ADDR_MP3_VOL = 12'h804;
  localparam logic [11:0] ADDR_MP3_SW  = 12'h80C;
  localparam logic [11:0] ADDR_SWITCH  = 12'h810;
  localparam logic [11:0] ADDR_BTN     = 12'h814;
  localparam logic [11:0] ADDR_LED     = 12'h818;
  localparam logic [11:0] ADDR_VOL     = 12'h840;
  localparam logic [11:0] ADDR_SD_BUF  = 12'h844;
  localparam logic [11:0] ADDR_SD      = 12'h848;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DMEM_WAIT = 3'd1,
    ST_SD_REQ    = 3'd2,
    ST_SD_WAIT   = 3'd3,
    ST_DONE      = 3'd4
  } rd_state_e;

  // Where a load is served from, as decided by the address decode
  typedef enum logic [1:0] {
    SRC_DMEM     = 2'd0,
    SRC_FAST     = 2'd1,
    SRC_SLOW     = 2'd2,
    SRC_UNMAPPED = 2'd3
  } rd_src_e;

endpackage

// File: rtl/btn_event_latch.sv
// Per-bit rising-edge detector with sticky event latches. A clear
// request wipes the latches, but an edge arriving in the same cycle
// survives so no button press is ever lost.
module btn_event_latch #(
  parameter int BTN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BTN_W-1:0] btn,
  input  logic             clr,
  output logic [BTN_W-1:0] lat
);

  logic [BTN_W-1:0] btn_prev;
  logic [BTN_W-1:0] rise;

  assign rise = btn & ~btn_prev;

  // Remember last cycle's button levels for edge detection
  always_ff @(posedge clk) begin
    if (rst) btn_prev <= '0;
    else     btn_prev <= btn;
  end

  // Sticky latch: clear-on-read, with a new edge taking priority
  always_ff @(posedge clk) begin
    if (rst) lat <= '0;
    else     lat <= (clr ? '0 : lat) | rise;
  end

endmodule

// File: rtl/interface_i_rd.sv
// Read-side memory-mapped decoder. Routes CPU loads to DMEM or to a
// peripheral readback, stalls the CPU until RDATA is registered, and
// talks to the slow SD buffer through a req/ack handshake with timeout.
module interface_i_rd
  import interface_io_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEAD_BEEF,
  parameter int          BTN_W    = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [31:0]      ADDR,
  input  logic             RE,
  input  logic [31:0]      DMEM_RDATA,
  output logic             DMEM_RE,
  input  logic [31:0]      MP3_VOL_Q,
  input  logic [31:0]      MP3_SW_Q,
  input  logic [15:0]      SWITCH,
  input  logic [BTN_W-1:0] BTN,
  input  logic [31:0]      LED_Q,
  input  logic [31:0]      VOL_Q,
  input  logic [31:0]      SD_STATUS,
  output logic             SD_BUF_REQ,
  input  logic             SD_BUF_ACK,
  input  logic [31:0]      SD_BUF_DATA,
  output logic [31:0]      RDATA,
  output logic             STALL,
  output logic             RD_ERR
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  // Counter value in the last SD_WAIT cycle before the abort
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  rd_state_e        state_q;
  rd_state_e        state_d;
  rd_src_e          src;
  logic [31:0]      src_data;
  logic [BTN_W-1:0] btn_lat;
  logic             btn_clr;
  logic             rdata_ld;
  logic [31:0]      rdata_nxt;
  logic             err_set;
  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_addr_hi;

  // Only the low 12 address bits take part in the decode
  assign unused_addr_hi = ^ADDR[31:12];

  btn_event_latch #(
    .BTN_W (BTN_W)
  ) u_btn (
    .clk (CLK),
    .rst (RST),
    .btn (BTN),
    .clr (btn_clr),
    .lat (btn_lat)
  );

  // Address decode: pick the source class and the fast readback value
  always_comb begin
    src      = SRC_UNMAPPED;
    src_data = ERR_WORD;
    if (!ADDR[11]) begin
      src = SRC_DMEM;
    end else begin
      case (ADDR[11:0])
        ADDR_MP3_VOL: begin src = SRC_FAST; src_data = MP3_VOL_Q;         end
        ADDR_MP3_SW:  begin src = SRC_FAST; src_data = MP3_SW_Q;          end
        ADDR_SWITCH:  begin src = SRC_FAST; src_data = {16'b0, SWITCH};   end
        ADDR_BTN:     begin src = SRC_FAST; src_data = 32'(btn_lat);      end
        ADDR_LED:     begin src = SRC_FAST; src_data = LED_Q;             end
        ADDR_VOL:     begin src = SRC_FAST; src_data = VOL_Q;             end
        ADDR_SD_BUF:  begin src = SRC_SLOW;                               end
        ADDR_SD:      begin src = SRC_FAST; src_data = SD_STATUS;         end
        default:      begin src = SRC_UNMAPPED; src_data = ERR_WORD;      end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; an ACK wins over a simultaneous timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (RE) begin
          case (src)
            SRC_DMEM: state_d = ST_DMEM_WAIT;
            SRC_SLOW: state_d = ST_SD_REQ;
            default:  state_d = ST_DONE;
          endcase
        end
      end
      ST_DMEM_WAIT: state_d = ST_DONE;
      ST_SD_REQ:    state_d = SD_BUF_ACK ? ST_DONE : ST_SD_WAIT;
      ST_SD_WAIT: begin
        if (SD_BUF_ACK || (cnt_q == CNT_LAST)) state_d = ST_DONE;
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: CPU hold, strobes and datapath load controls
  always_comb begin
    STALL      = 1'b0;
    DMEM_RE    = 1'b0;
    SD_BUF_REQ = 1'b0;
    rdata_ld   = 1'b0;
    rdata_nxt  = SD_BUF_DATA;
    err_set    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    btn_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (RE) begin
          STALL = 1'b1;
          case (src)
            SRC_DMEM: DMEM_RE = 1'b1;
            SRC_FAST: begin
              rdata_ld  = 1'b1;
              rdata_nxt = src_data;
              btn_clr   = (ADDR[11:0] == ADDR_BTN);
            end
            SRC_UNMAPPED: begin
              rdata_ld  = 1'b1;
              rdata_nxt = ERR_WORD;
              err_set   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_DMEM_WAIT: begin
        STALL     = 1'b1;
        rdata_ld  = 1'b1;
        rdata_nxt = DMEM_RDATA;
      end
      ST_SD_REQ: begin
        STALL      = 1'b1;
        SD_BUF_REQ = 1'b1;
        cnt_clr    = 1'b1;
        rdata_ld   = SD_BUF_ACK;
        rdata_nxt  = SD_BUF_DATA;
      end
      ST_SD_WAIT: begin
        STALL = 1'b1;
        if (SD_BUF_ACK) begin
          rdata_ld  = 1'b1;
          rdata_nxt = SD_BUF_DATA;
        end else if (cnt_q == CNT_LAST) begin
          rdata_ld  = 1'b1;
          rdata_nxt = ERR_WORD;
          err_set   = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Read data register, sticky error flag and SD timeout counter
  always_ff @(posedge CLK) begin
    if (RST) begin
      RDATA  <= '0;
      RD_ERR <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (rdata_ld) RDATA  <= rdata_nxt;
      if (err_set)  RD_ERR <= 1'b1;
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_interface_i_rd.sv
`timescale 1ns/1ps
module tb_interface_i_rd;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
  localparam int          BW   = 5;

  logic          CLK = 1'b0;
  logic          RST;
  logic [31:0]   ADDR;
  logic          RE;
  logic [31:0]   DMEM_RDATA;
  logic          DMEM_RE;
  logic [31:0]   MP3_VOL_Q;
  logic [31:0]   MP3_SW_Q;
  logic [15:0]   SWITCH;
  logic [BW-1:0] BTN;
  logic [31:0]   LED_Q;
  logic [31:0]   VOL_Q;
  logic [31:0]   SD_STATUS;
  logic          SD_BUF_REQ;
  logic          SD_BUF_ACK;
  logic [31:0]   SD_BUF_DATA;
  logic [31:0]   RDATA;
  logic          STALL;
  logic          RD_ERR;

  interface_i_rd #(.TIMEOUT(TO), .ERR_WORD(ERRW), .BTN_W(BW)) dut (
    .CLK(CLK), .RST(RST), .ADDR(ADDR), .RE(RE),
    .DMEM_RDATA(DMEM_RDATA), .DMEM_RE(DMEM_RE),
    .MP3_VOL_Q(MP3_VOL_Q), .MP3_SW_Q(MP3_SW_Q), .SWITCH(SWITCH), .BTN(BTN),
    .LED_Q(LED_Q), .VOL_Q(VOL_Q), .SD_STATUS(SD_STATUS),
    .SD_BUF_REQ(SD_BUF_REQ), .SD_BUF_ACK(SD_BUF_ACK), .SD_BUF_DATA(SD_BUF_DATA),
    .RDATA(RDATA), .STALL(STALL), .RD_ERR(RD_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: expected button latches and sticky error flag
  logic [BW-1:0] exp_lat = '0;
  bit            exp_err = 1'b0;

  // Expected readback of a fast peripheral, straight from the address map
  function automatic logic [31:0] fast_val(input logic [11:0] a);
    case (a)
      12'h804: return MP3_VOL_Q;
      12'h80C: return MP3_SW_Q;
      12'h810: return {16'h0, SWITCH};
      12'h814: return 32'(exp_lat);
      12'h818: return LED_Q;
      12'h840: return VOL_Q;
      12'h848: return SD_STATUS;
      default: return ERRW;
    endcase
  endfunction

  // Change the buttons and let one clock pass so the edge is captured
  task automatic btn_set(input logic [BW-1:0] v);
    exp_lat = exp_lat | (v & ~BTN);
    BTN = v;
    @(negedge CLK);
  endtask

  // One CPU load, called and returning at a falling edge. Counts stall
  // cycles and strobes, plays DMEM and the SD buffer (ACK ack_dly
  // cycles after REQ), and returns RDATA seen in the first unstalled cycle.
  task automatic cpu_read(input logic [31:0] addr, input int ack_dly,
                          input logic [31:0] dm_data, input logic [31:0] sd_data,
                          output logic [31:0] rd, output int stalls,
                          output int n_dre, output int n_req, output bit hung);
    int req_cyc;
    bit dre_prev;
    req_cyc = -1; dre_prev = 1'b0;
    stalls = 0; n_dre = 0; n_req = 0; hung = 1'b1; rd = '0;
    ADDR = addr; RE = 1'b1;
    for (int c = 0; c < 64; c++) begin
      DMEM_RDATA  = dre_prev ? dm_data : $urandom();
      SD_BUF_ACK  = 1'b0;
      SD_BUF_DATA = $urandom();
      #1;
      dre_prev = DMEM_RE;
      if (DMEM_RE) n_dre++;
      if (SD_BUF_REQ) begin n_req++; req_cyc = c; end
      if (req_cyc >= 0 && (c - req_cyc) == ack_dly) begin
        SD_BUF_ACK  = 1'b1;
        SD_BUF_DATA = sd_data;
      end
      if (!STALL) begin rd = RDATA; hung = 1'b0; break; end
      stalls++;
      @(negedge CLK);
    end
    RE = 1'b0; SD_BUF_ACK = 1'b0; ADDR = $urandom();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; RE = 1'b0; ADDR = '0; SD_BUF_ACK = 1'b0; BTN = '0;
    DMEM_RDATA = '0; SD_BUF_DATA = '0; MP3_VOL_Q = '0; MP3_SW_Q = '0;
    SWITCH = '0; LED_Q = '0; VOL_Q = '0; SD_STATUS = '0;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", RDATA); end
    n_checks++; if ({STALL, DMEM_RE, SD_BUF_REQ, RD_ERR} !== 4'b0) begin n_fail++;
      $display("FAIL reset_ctrl: got %b want 0000", {STALL, DMEM_RE, SD_BUF_REQ, RD_ERR}); end
    RST = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_dmem();
    logic [31:0] rd; int st, nd, nr; bit hung;
    cpu_read(32'h0000_0100, 99, 32'h1234_5678, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h1234_5678) begin n_fail++; $display("FAIL dmem_rdata: got %h want 12345678", rd); end
    n_checks++; if (st != 2) begin n_fail++; $display("FAIL dmem_stall: got %0d want 2", st); end
    n_checks++; if (nd != 1 || nr != 0) begin n_fail++; $display("FAIL dmem_strobes: dre %0d req %0d want 1 0", nd, nr); end
  endtask

  task automatic test_switch();
    logic [31:0] rd; int st, nd, nr; bit hung;
    SWITCH = 16'hA5C3;
    cpu_read(32'h0000_0810, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h0000_A5C3) begin n_fail++; $display("FAIL switch_rdata: got %h want 0000a5c3", rd); end
    n_checks++; if (st != 1) begin n_fail++; $display("FAIL switch_stall: got %0d want 1", st); end
    n_checks++; if (RD_ERR !== 1'b0) begin n_fail++; $display("FAIL switch_rd_err: got %b want 0", RD_ERR); end
  endtask

  task automatic test_sd_ack();
    logic [31:0] rd; int st, nd, nr; bit hung;
    cpu_read(32'h0000_0844, 3, 32'h0, 32'hCAFE_0001, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'hCAFE_0001) begin n_fail++; $display("FAIL sd_rdata: got %h want cafe0001", rd); end
    n_checks++; if (st != 5) begin n_fail++; $display("FAIL sd_stall: got %0d want 5", st); end
    n_checks++; if (nr != 1 || nd != 0) begin n_fail++; $display("FAIL sd_req_pulses: req %0d dre %0d want 1 0", nr, nd); end
  endtask

  task automatic test_btn();
    logic [31:0] rd; int st, nd, nr; bit hung;
    btn_set(5'b00100);
    cpu_read(32'h0000_0814, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h4) begin n_fail++; $display("FAIL btn_first: got %h want 4", rd); end
    cpu_read(32'h0000_0814, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h0) begin n_fail++; $display("FAIL btn_cleared: got %h want 0", rd); end
    btn_set(5'b00000);
    // BTN[0] rises in the same cycle as the read that clears the latch
    BTN = 5'b00001;
    cpu_read(32'h0000_0814, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h0) begin n_fail++; $display("FAIL btn_clear_cycle: got %h want 0", rd); end
    cpu_read(32'h0000_0814, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h1) begin n_fail++; $display("FAIL btn_set_wins: got %h want 1", rd); end
    exp_lat = '0;
  endtask

  task automatic test_timeout();
    logic [31:0] rd; int st, nd, nr; bit hung;
    cpu_read(32'h0000_0844, 1000, 32'h0, 32'h0, rd, st, nd, nr, hung);
    exp_err = 1'b1;
    n_checks++; if (hung || rd !== ERRW) begin n_fail++; $display("FAIL timeout_rdata: got %h want %h", rd, ERRW); end
    n_checks++; if (st != 2 + TO) begin n_fail++; $display("FAIL timeout_stall: got %0d want %0d", st, 2 + TO); end
    n_checks++; if (RD_ERR !== 1'b1 || nr != 1) begin n_fail++; $display("FAIL timeout_err: rd_err %b req %0d want 1 1", RD_ERR, nr); end
    // Late ACK with nothing outstanding
    SD_BUF_ACK = 1'b1; SD_BUF_DATA = 32'h1111_2222;
    @(negedge CLK);
    SD_BUF_ACK = 1'b0;
    #1;
    n_checks++; if (RDATA !== ERRW || STALL !== 1'b0) begin n_fail++;
      $display("FAIL stray_ack: rdata %h stall %b want %h 0", RDATA, STALL, ERRW); end
    @(negedge CLK);
  endtask

  task automatic test_sd_reset();
    ADDR = 32'h0000_0844; RE = 1'b1; SD_BUF_ACK = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL sdrst_pre_stall: got %b want 1", STALL); end
    RST = 1'b1; RE = 1'b0;
    @(negedge CLK);
    #1;
    exp_err = 1'b0; exp_lat = '0;
    n_checks++; if ({STALL, DMEM_RE, SD_BUF_REQ, RD_ERR} !== 4'b0) begin n_fail++;
      $display("FAIL sdrst_ctrl: got %b want 0000", {STALL, DMEM_RE, SD_BUF_REQ, RD_ERR}); end
    n_checks++; if (RDATA !== 32'h0) begin n_fail++; $display("FAIL sdrst_rdata: got %h want 0", RDATA); end
    RST = 1'b0;
    @(negedge CLK);
    SD_BUF_ACK = 1'b1; SD_BUF_DATA = 32'h5555_AAAA;
    @(negedge CLK);
    SD_BUF_ACK = 1'b0;
    #1;
    n_checks++; if (RDATA !== 32'h0 || STALL !== 1'b0) begin n_fail++;
      $display("FAIL sdrst_late_ack: rdata %h stall %b want 0 0", RDATA, STALL); end
    @(negedge CLK);
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; int st, nd, nr; bit hung;
    n_checks++; if (RD_ERR !== 1'b0) begin n_fail++; $display("FAIL unmapped_pre_err: got %b want 0", RD_ERR); end
    cpu_read(32'h0000_08F0, 99, 32'h0, 32'h0, rd, st, nd, nr, hung);
    exp_err = 1'b1;
    n_checks++; if (hung || rd !== ERRW) begin n_fail++; $display("FAIL unmapped_rdata: got %h want %h", rd, ERRW); end
    n_checks++; if (RD_ERR !== 1'b1 || st != 1) begin n_fail++; $display("FAIL unmapped_err: rd_err %b stall %0d want 1 1", RD_ERR, st); end
  endtask

  task automatic test_ack_in_req();
    logic [31:0] rd; int st, nd, nr; bit hung;
    cpu_read(32'h0000_0844, 0, 32'h0, 32'h0BAD_F00D, rd, st, nd, nr, hung);
    n_checks++; if (hung || rd !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL ack_in_req_rdata: got %h want 0badf00d", rd); end
    n_checks++; if (st != 2) begin n_fail++; $display("FAIL ack_in_req_stall: got %0d want 2", st); end
  endtask

  task automatic test_random();
    logic [11:0] unm  [5] = '{12'h800, 12'h808, 12'h81C, 12'h8F0, 12'hFFC};
    logic [11:0] fast [7] = '{12'h804, 12'h80C, 12'h810, 12'h814, 12'h818, 12'h840, 12'h848};
    logic [31:0] a, dm, sd, rd, exp_v;
    int k, d, st, nd, nr, exp_st, exp_dre, exp_req;
    bit hung;
    for (int i = 0; i < 60; i++) begin
      MP3_VOL_Q = $urandom(); MP3_SW_Q = $urandom(); SWITCH = 16'($urandom());
      LED_Q = $urandom(); VOL_Q = $urandom(); SD_STATUS = $urandom();
      if ($urandom_range(0, 2) == 0) btn_set(BW'($urandom()));
      dm = $urandom(); sd = $urandom(); a = $urandom();
      k = $urandom_range(0, 3); d = $urandom_range(0, 6);
      exp_dre = 0; exp_req = 0;
      case (k)
        0: begin a[11] = 1'b0; exp_v = dm; exp_st = 2; exp_dre = 1; end
        1: begin
          a[11:0] = fast[$urandom_range(0, 6)];
          exp_v = fast_val(a[11:0]); exp_st = 1;
          if (a[11:0] == 12'h814) exp_lat = '0;
        end
        2: begin
          a[11:0] = 12'h844; exp_req = 1;
          if (d <= TO) begin exp_v = sd; exp_st = 2 + d; end
          else begin exp_v = ERRW; exp_st = 2 + TO; exp_err = 1'b1; end
        end
        default: begin a[11:0] = unm[$urandom_range(0, 4)]; exp_v = ERRW; exp_st = 1; exp_err = 1'b1; end
      endcase
      cpu_read(a, d, dm, sd, rd, st, nd, nr, hung);
      n_checks++; if (hung || rd !== exp_v) begin n_fail++; $display("FAIL rand_rdata[%0d] addr %h: got %h want %h", i, a, rd, exp_v); end
      n_checks++; if (st != exp_st) begin n_fail++; $display("FAIL rand_stall[%0d] addr %h: got %0d want %0d", i, a, st, exp_st); end
      n_checks++; if (nd != exp_dre || nr != exp_req) begin n_fail++;
        $display("FAIL rand_strobes[%0d] addr %h: dre %0d req %0d want %0d %0d", i, a, nd, nr, exp_dre, exp_req); end
      n_checks++; if (RD_ERR !== exp_err) begin n_fail++; $display("FAIL rand_rd_err[%0d]: got %b want %b", i, RD_ERR, exp_err); end
    end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_dmem();
    test_switch();
    test_sd_ack();
    test_btn();
    test_timeout();
    test_sd_reset();
    test_unmapped();
    test_ack_in_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
